// File: rtl/disk_head_ctrl.sv
// Disk II head positioner and track/save handshake feeding the SD track loader.
// Decodes stepper phases into a half-track position and generates the rotating track RAM address.
module disk_head_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  phase,
    input  logic        motor_on,
    input  logic        byte_tick,
    input  logic        write_strobe,
    input  logic        busy,
    output logic [5:0]  track,
    output logic        save_track,
    output logic        dirty,
    output logic [12:0] track_addr
);
    localparam logic [6:0]  HT_MAX    = 7'd69;
    localparam logic [12:0] ADDR_LAST = 13'd6655;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    logic [6:0]  ht;
    logic        motor_q;
    logic [1:0]  c_out;
    logic [1:0]  c_in;
    logic        step_out;
    logic        step_in;
    logic [5:0]  target;
    logic        motor_fall;

    // Adjacent magnets relative to the current quarter-phase; 2-bit wrap gives the mod-4.
    always_comb begin
        c_out    = ht[1:0] + 2'd1;
        c_in     = ht[1:0] + 2'd3;
        step_out = motor_on & phase[c_out] & ~phase[c_in];
        step_in  = motor_on & phase[c_in]  & ~phase[c_out];
    end

    assign target     = ht[6:1];
    assign motor_fall = motor_q & ~motor_on;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ht      <= '0;
            motor_q <= 1'b0;
        end else begin
            motor_q <= motor_on;
            if (step_out && ht != HT_MAX)
                ht <= ht + 7'd1;
            else if (step_in && ht != 7'd0)
                ht <= ht - 7'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            track_addr <= '0;
        else if (motor_on && byte_tick)
            track_addr <= (track_addr == ADDR_LAST) ? 13'd0 : track_addr + 13'd1;
    end

    // track stays frozen on the old value until the loader has latched the save.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            track      <= '0;
            save_track <= 1'b0;
            dirty      <= 1'b0;
        end else begin
            if (write_strobe && !busy)
                dirty <= 1'b1;
            case (state)
                IDLE: begin
                    if (!dirty)
                        track <= target;
                    else if (target != track || motor_fall) begin
                        save_track <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (busy) begin
                        save_track <= 1'b0;
                        dirty      <= 1'b0;
                        track      <= target;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (!busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_disk_head_ctrl.sv
// Bench for disk_head_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_disk_head_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  phase;
    logic        motor_on;
    logic        byte_tick;
    logic        write_strobe;
    logic        busy;
    logic [5:0]  track;
    logic        save_track;
    logic        dirty;
    logic [12:0] track_addr;

    int checks = 0;
    int failures = 0;

    // behavioural model
    int m_ht, m_track, m_addr;
    bit m_save, m_dirty, m_saving, m_draining, m_motor_prev;

    disk_head_ctrl dut (
        .clk(clk), .reset_n(reset_n), .phase(phase), .motor_on(motor_on),
        .byte_tick(byte_tick), .write_strobe(write_strobe), .busy(busy),
        .track(track), .save_track(save_track), .dirty(dirty), .track_addr(track_addr)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_ht = 0; m_track = 0; m_addr = 0;
        m_save = 0; m_dirty = 0; m_saving = 0; m_draining = 0; m_motor_prev = 0;
    endtask

    // Advance one clock; model consumes the inputs present before the edge.
    task automatic step();
        int n_ht, n_track, n_addr, cur, tgt;
        bit n_save, n_dirty, n_saving, n_draining, outward, inward;
        n_ht = m_ht; n_track = m_track; n_addr = m_addr;
        n_save = m_save; n_dirty = m_dirty; n_saving = m_saving; n_draining = m_draining;
        tgt = m_ht / 2;
        cur = m_ht % 4;
        outward = phase[(cur + 1) % 4] && !phase[(cur + 3) % 4];
        inward  = phase[(cur + 3) % 4] && !phase[(cur + 1) % 4];
        if (motor_on) begin
            if (outward && m_ht < 69) n_ht = m_ht + 1;
            else if (inward && m_ht > 0) n_ht = m_ht - 1;
        end
        if (write_strobe && !busy) n_dirty = 1;
        if (m_saving) begin
            if (busy) begin
                n_save = 0; n_dirty = 0; n_track = tgt; n_saving = 0; n_draining = 1;
            end
        end else if (m_draining) begin
            if (!busy) n_draining = 0;
        end else if (!m_dirty) begin
            n_track = tgt;
        end else if (tgt != m_track || (m_motor_prev && !motor_on)) begin
            n_save = 1; n_saving = 1;
        end
        if (motor_on && byte_tick) n_addr = (m_addr + 1) % 6656;
        @(posedge clk);
        m_ht = n_ht; m_track = n_track; m_addr = n_addr; m_save = n_save;
        m_dirty = n_dirty; m_saving = n_saving; m_draining = n_draining; m_motor_prev = motor_on;
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (track !== 6'd0) begin failures++; $display("FAIL reset_track got=%0d exp=0", track); end
        checks++; if (save_track !== 1'b0) begin failures++; $display("FAIL reset_save got=%b exp=0", save_track); end
        checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL reset_dirty got=%b exp=0", dirty); end
        checks++; if (track_addr !== 13'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", track_addr); end
    endtask

    task automatic test_step_up();
        bit saw_save = 0;
        apply_reset();
        motor_on = 1'b1;
        phase = 4'b0010;
        repeat (4) begin step(); if (save_track) saw_save = 1; end
        phase = 4'b0100;
        repeat (4) begin step(); if (save_track) saw_save = 1; end
        phase = 4'b0000;
        checks++; if (dut.ht !== 7'd2) begin failures++; $display("FAIL step_up_ht got=%0d exp=2", dut.ht); end
        checks++; if (track !== 6'd1) begin failures++; $display("FAIL step_up_track got=%0d exp=1", track); end
        checks++; if (saw_save) begin failures++; $display("FAIL step_up_nosave got=1 exp=0"); end
    endtask

    task automatic test_bounds();
        apply_reset();
        motor_on = 1'b1;
        phase = 4'b1000;
        repeat (3) step();
        checks++; if (dut.ht !== 7'd0) begin failures++; $display("FAIL bound_low_ht got=%0d exp=0", dut.ht); end
        checks++; if (track !== 6'd0) begin failures++; $display("FAIL bound_low_track got=%0d exp=0", track); end
        for (int i = 0; i < 150; i++) begin
            phase = 4'(1 << ((m_ht + 1) % 4));
            step();
        end
        checks++; if (dut.ht !== 7'd69) begin failures++; $display("FAIL bound_high_ht got=%0d exp=69", dut.ht); end
        checks++; if (track !== 6'd34) begin failures++; $display("FAIL bound_high_track got=%0d exp=34", track); end
        for (int i = 0; i < 100 && m_ht > 10; i++) begin
            phase = 4'(1 << ((m_ht + 3) % 4));
            step();
        end
        phase = 4'b0000;
        repeat (2) step();
        checks++; if (track !== 6'd5) begin failures++; $display("FAIL bound_return_track got=%0d exp=5", track); end
    endtask

    task automatic test_save();
        bit held = 1;
        bit seen = 0;
        write_strobe = 1'b1; step(); write_strobe = 1'b0;
        checks++; if (dirty !== 1'b1) begin failures++; $display("FAIL save_dirty_set got=%b exp=1", dirty); end
        for (int i = 0; i < 10 && m_ht < 12; i++) begin
            phase = 4'(1 << ((m_ht + 1) % 4));
            step();
        end
        phase = 4'b0000;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (save_track === 1'b1) seen = 1; else step();
        end
        checks++; if (!seen) begin failures++; $display("FAIL save_req_timeout got=0 exp=1"); end
        checks++; if (track !== 6'd5) begin failures++; $display("FAIL save_req_track got=%0d exp=5", track); end
        repeat (10) begin step(); if (save_track !== 1'b1 || track !== 6'd5) held = 0; end
        checks++; if (!held) begin failures++; $display("FAIL save_hold got=dropped exp=held"); end
        busy = 1'b1; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
        checks++; if (save_track !== 1'b0) begin failures++; $display("FAIL save_ack_save got=%b exp=0", save_track); end
        checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL save_ack_dirty got=%b exp=0", dirty); end
        checks++; if (track !== 6'd6) begin failures++; $display("FAIL save_ack_track got=%0d exp=6", track); end
        busy = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 10 && m_ht < 14; i++) begin
            phase = 4'(1 << ((m_ht + 1) % 4));
            step();
        end
        phase = 4'b0000;
        repeat (2) step();
        checks++; if (track !== 6'd7) begin failures++; $display("FAIL save_idle_follow got=%0d exp=7", track); end
    endtask

    task automatic test_motor_off();
        for (int i = 0; i < 20 && m_ht > 6; i++) begin
            phase = 4'(1 << ((m_ht + 3) % 4));
            step();
        end
        phase = 4'b0000;
        repeat (2) step();
        checks++; if (track !== 6'd3) begin failures++; $display("FAIL moff_pre_track got=%0d exp=3", track); end
        write_strobe = 1'b1; step(); write_strobe = 1'b0;
        motor_on = 1'b0;
        step();
        checks++; if (save_track !== 1'b1) begin failures++; $display("FAIL moff_save got=%b exp=1", save_track); end
        checks++; if (track !== 6'd3) begin failures++; $display("FAIL moff_req_track got=%0d exp=3", track); end
        busy = 1'b1; step();
        busy = 1'b0; repeat (2) step();
        checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL moff_dirty got=%b exp=0", dirty); end
        checks++; if (save_track !== 1'b0) begin failures++; $display("FAIL moff_save_clr got=%b exp=0", save_track); end
        checks++; if (track !== 6'd3) begin failures++; $display("FAIL moff_track got=%0d exp=3", track); end
        motor_on = 1'b1;
    endtask

    task automatic test_addr();
        motor_on = 1'b1;
        byte_tick = 1'b1;
        for (int i = 0; i < 7000 && m_addr != 6655; i++) step();
        checks++; if (track_addr !== 13'd6655) begin failures++; $display("FAIL addr_last got=%0d exp=6655", track_addr); end
        step();
        checks++; if (track_addr !== 13'd0) begin failures++; $display("FAIL addr_wrap got=%0d exp=0", track_addr); end
        motor_on = 1'b0;
        step();
        checks++; if (track_addr !== 13'd0) begin failures++; $display("FAIL addr_motor_off got=%0d exp=0", track_addr); end
        byte_tick = 1'b0;
        motor_on = 1'b1;
        step();
    endtask

    task automatic test_busy_write();
        busy = 1'b1; write_strobe = 1'b1; step();
        busy = 1'b0; write_strobe = 1'b0; step();
        checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL busy_write_dirty got=%b exp=0", dirty); end
    endtask

    task automatic test_reset_mid_save();
        bit seen = 0;
        apply_reset();
        motor_on = 1'b1;
        for (int i = 0; i < 10 && m_ht < 4; i++) begin phase = 4'(1 << ((m_ht + 1) % 4)); step(); end
        phase = 4'b0000; repeat (2) step();
        write_strobe = 1'b1; step(); write_strobe = 1'b0;
        for (int i = 0; i < 10 && m_ht < 6; i++) begin phase = 4'(1 << ((m_ht + 1) % 4)); step(); end
        phase = 4'b0000;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (save_track === 1'b1) seen = 1; else step();
        end
        checks++; if (!seen || track !== 6'd2) begin failures++; $display("FAIL rst_mid_pre got=save%b/trk%0d exp=save1/trk2", save_track, track); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (save_track !== 1'b0) begin failures++; $display("FAIL rst_mid_save got=%b exp=0", save_track); end
        checks++; if (track !== 6'd0) begin failures++; $display("FAIL rst_mid_track got=%0d exp=0", track); end
        checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL rst_mid_dirty got=%b exp=0", dirty); end
        model_clear();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 4000; i++) begin
            phase        = 4'($urandom_range(0, 15));
            motor_on     = ($urandom_range(0, 7) != 0);
            byte_tick    = $urandom_range(0, 1) == 1;
            write_strobe = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) busy = ~busy;
            step();
            checks++;
            if (track !== 6'(m_track) || save_track !== m_save || dirty !== m_dirty || track_addr !== 13'(m_addr)) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random_cyc%0d got=trk%0d/sv%b/dt%b/ad%0d exp=trk%0d/sv%b/dt%b/ad%0d", i,
                             track, save_track, dirty, track_addr, m_track, m_save, m_dirty, m_addr);
                bad++;
            end
        end
        busy = 1'b0; write_strobe = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; phase = 4'b0000; motor_on = 1'b0; byte_tick = 1'b0;
        write_strobe = 1'b0; busy = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        test_step_up();
        test_bounds();
        test_save();
        test_motor_off();
        test_addr();
        test_busy_write();
        test_reset_mid_save();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
